// File: rtl/mac_tile_sequencer.sv
// Tile walker for a square systolic MAC array. It steps through rows (WROW), then depth (KIDX), then columns (ICOL). Defining MAC_TILE_SEQ_ABORT_EN adds the Abort input.
// Latency: all outputs are registered and change one edge after Start or Tile_Done. There is no backpressure; the block waits for one Tile_Done per pass.
module mac_tile_sequencer #(
  parameter int ARR = 4,
  parameter int DW  = 6,
  parameter int TW  = 4,
  parameter int SHW = $clog2(ARR*8)+1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Start,
  input  logic [DW-1:0]         M,
  input  logic [DW-1:0]         N,
  input  logic [DW-1:0]         T,
  input  logic                  Tile_Done,
`ifdef MAC_TILE_SEQ_ABORT_EN
  input  logic                  Abort,
`endif
  output logic                  Busy,
  output logic                  Done,
  output logic                  Cfg_Err,
  output logic                  LOAD,
  output logic                  START_CALC,
  output logic                  Acc,
  output logic [TW-1:0]         WROW,
  output logic [TW-1:0]         KIDX,
  output logic [TW-1:0]         ICOL,
  output logic [2*TW-1:0]       ODST,
  output logic [SHW-1:0]        shI,
  output logic [SHW-1:0]        shW,
  output logic [$clog2(ARR):0]  VROWS,
  output logic [$clog2(ARR):0]  VCOLS
);

  localparam int LG = $clog2(ARR);
  localparam int VW = LG + 1;
  localparam int XW = DW + 2*TW + 8;

  typedef enum logic [1:0] {S_IDLE, S_LOAD_W, S_RUN, S_FIN} state_t;

  state_t          r_state;
  logic [DW-1:0]   r_m, r_n, r_t;
  logic [TW-1:0]   r_wrow, r_kidx, r_icol;
  logic            r_busy, r_done, r_cfg_err, r_load, r_start_calc, r_acc;
  logic [2*TW-1:0] r_odst;
  logic [SHW-1:0]  r_shi, r_shw;
  logic [VW-1:0]   r_vrows, r_vcols;

  logic            w_dims_zero, w_accept, w_abort, w_advance, w_finish, w_upd;
  logic            w_last_m, w_last_k, w_last_t;
  logic [TW:0]     w_tot_m, w_tot_k, w_tot_t;
  logic [TW-1:0]   w_nxt_wrow, w_nxt_kidx, w_nxt_icol;
  logic [DW-1:0]   w_dm, w_dn, w_dt;
  logic [VW-1:0]   w_nxt_vrows, w_nxt_vcols, w_nxt_remk;
  logic [SHW-1:0]  w_nxt_sh;
  logic [2*TW-1:0] w_nxt_odst;

  function automatic logic [TW:0] f_ceil(input logic [DW-1:0] x);
    return (TW+1)'((XW'(x) + XW'(ARR - 1)) >> LG);
  endfunction

  // Valid extent of a tile: min(ARR, dim - idx*ARR)
  function automatic logic [VW-1:0] f_valid(input logic [DW-1:0] dim, input logic [TW-1:0] idx);
    logic [XW-1:0] rem;
    rem = XW'(dim) - (XW'(idx) << LG);
    if (rem >= XW'(ARR))
      return VW'(ARR);
    else
      return VW'(rem);
  endfunction

  function automatic logic [SHW-1:0] f_shift(input logic [VW-1:0] v);
    return SHW'((XW'(ARR) - XW'(v)) << 3);
  endfunction

`ifdef MAC_TILE_SEQ_ABORT_EN
  assign w_abort = Abort && (r_state != S_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  assign w_dims_zero = (M == '0) || (N == '0) || (T == '0);
  assign w_accept    = (r_state == S_IDLE) && Start && !w_dims_zero;

  assign w_tot_m  = f_ceil(r_m);
  assign w_tot_k  = f_ceil(r_n);
  assign w_tot_t  = f_ceil(r_t);
  assign w_last_m = ((TW+1)'(r_wrow) == w_tot_m - (TW+1)'(1));
  assign w_last_k = ((TW+1)'(r_kidx) == w_tot_k - (TW+1)'(1));
  assign w_last_t = ((TW+1)'(r_icol) == w_tot_t - (TW+1)'(1));

  assign w_advance = (r_state == S_RUN) && Tile_Done && !w_abort;
  assign w_finish  = w_last_m && w_last_k && w_last_t;
  assign w_upd     = w_accept || w_abort || (w_advance && !w_finish);

  // A freshly accepted job derives its tile geometry from the inputs, not the stale registers
  assign w_dm = w_accept ? M : r_m;
  assign w_dn = w_accept ? N : r_n;
  assign w_dt = w_accept ? T : r_t;

  always_comb begin
    w_nxt_wrow = r_wrow;
    w_nxt_kidx = r_kidx;
    w_nxt_icol = r_icol;
    if (w_abort || w_accept) begin
      w_nxt_wrow = '0;
      w_nxt_kidx = '0;
      w_nxt_icol = '0;
    end else if (w_advance && !w_finish) begin
      if (!w_last_t) begin
        w_nxt_icol = r_icol + TW'(1);
      end else begin
        w_nxt_icol = '0;
        if (!w_last_k) begin
          w_nxt_kidx = r_kidx + TW'(1);
        end else begin
          w_nxt_kidx = '0;
          w_nxt_wrow = r_wrow + TW'(1);
        end
      end
    end
  end

  assign w_nxt_vrows = f_valid(w_dm, w_nxt_wrow);
  assign w_nxt_vcols = f_valid(w_dt, w_nxt_icol);
  assign w_nxt_remk  = f_valid(w_dn, w_nxt_kidx);
  assign w_nxt_sh    = f_shift(w_nxt_remk);
  assign w_nxt_odst  = (2*TW)'(XW'(w_nxt_wrow) * XW'(f_ceil(w_dt)) + XW'(w_nxt_icol));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_m          <= '0;
      r_n          <= '0;
      r_t          <= '0;
      r_wrow       <= '0;
      r_kidx       <= '0;
      r_icol       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_load       <= 1'b0;
      r_start_calc <= 1'b0;
      r_acc        <= 1'b0;
      r_odst       <= '0;
      r_shi        <= '0;
      r_shw        <= '0;
      r_vrows      <= '0;
      r_vcols      <= '0;
    end else begin
      r_load    <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;

      if (w_upd) begin
        r_wrow  <= w_nxt_wrow;
        r_kidx  <= w_nxt_kidx;
        r_icol  <= w_nxt_icol;
        r_acc   <= (w_nxt_kidx != '0);
        r_odst  <= w_nxt_odst;
        r_shi   <= w_nxt_sh;
        r_shw   <= w_nxt_sh;
        r_vrows <= w_nxt_vrows;
        r_vcols <= w_nxt_vcols;
      end

      if (w_abort) begin
        r_state      <= S_IDLE;
        r_busy       <= 1'b0;
        r_start_calc <= 1'b0;
        r_done       <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (Start) begin
              if (w_dims_zero) begin
                r_cfg_err <= 1'b1;
              end else begin
                r_m     <= M;
                r_n     <= N;
                r_t     <= T;
                r_busy  <= 1'b1;
                r_load  <= 1'b1;
                r_state <= S_LOAD_W;
              end
            end
          end
          S_LOAD_W: begin
            r_start_calc <= 1'b1;
            r_state      <= S_RUN;
          end
          S_RUN: begin
            if (Tile_Done) begin
              if (w_finish) begin
                r_start_calc <= 1'b0;
                r_state      <= S_FIN;
              end else if (w_last_t) begin
                // Column wrap moves to a new (row, depth) weight tile
                r_start_calc <= 1'b0;
                r_load       <= 1'b1;
                r_state      <= S_LOAD_W;
              end
            end
          end
          S_FIN: begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign Busy       = r_busy;
  assign Done       = r_done;
  assign Cfg_Err    = r_cfg_err;
  assign LOAD       = r_load;
  assign START_CALC = r_start_calc;
  assign Acc        = r_acc;
  assign WROW       = r_wrow;
  assign KIDX       = r_kidx;
  assign ICOL       = r_icol;
  assign ODST       = r_odst;
  assign shI        = r_shi;
  assign shW        = r_shw;
  assign VROWS      = r_vrows;
  assign VCOLS      = r_vcols;

endmodule

// File: tb/tb_mac_tile_sequencer.sv
// Directed vector bench for mac_tile_sequencer with default parameters (ARR=4, DW=6, TW=4, SHW=6).
// Inputs change 1 time unit after a rising edge, and outputs are sampled at that same point.
module tb_mac_tile_sequencer;

  logic       CLK = 1'b0;
  logic       RST, Start, Tile_Done;
  logic [5:0] M, N, T;
`ifdef MAC_TILE_SEQ_ABORT_EN
  logic       Abort;
`endif
  logic       Busy, Done, Cfg_Err, LOAD, START_CALC, Acc;
  logic [3:0] WROW, KIDX, ICOL;
  logic [7:0] ODST;
  logic [5:0] shI, shW;
  logic [2:0] VROWS, VCOLS;

  always #5 CLK = ~CLK;

  mac_tile_sequencer dut (
    .CLK(CLK), .RST(RST), .Start(Start), .M(M), .N(N), .T(T), .Tile_Done(Tile_Done),
`ifdef MAC_TILE_SEQ_ABORT_EN
    .Abort(Abort),
`endif
    .Busy(Busy), .Done(Done), .Cfg_Err(Cfg_Err), .LOAD(LOAD), .START_CALC(START_CALC),
    .Acc(Acc), .WROW(WROW), .KIDX(KIDX), .ICOL(ICOL), .ODST(ODST),
    .shI(shI), .shW(shW), .VROWS(VROWS), .VCOLS(VCOLS)
  );

  typedef struct packed {
    logic       busy, done, err, load, sc, acc;
    logic [3:0] wrow, kidx, icol;
    logic [7:0] odst;
    logic [5:0] shi, shw;
    logic [2:0] vr, vc;
  } exp_t;

  typedef struct packed {
    logic       rst, start;
    logic [5:0] m, n, t;
    logic       td;
  } in_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t v(input logic rst, input logic st, input int m, input int n, input int t,
                             input logic td, input logic b, input logic d, input logic e,
                             input logic l, input logic s, input logic a, input int w,
                             input int k, input int i, input int o, input int sh,
                             input int vr, input int vc);
    vec_t r;
    r.i.rst = rst;  r.i.start = st; r.i.m = 6'(m); r.i.n = 6'(n); r.i.t = 6'(t); r.i.td = td;
    r.e.busy = b;   r.e.done = d;   r.e.err = e;   r.e.load = l;  r.e.sc = s;    r.e.acc = a;
    r.e.wrow = 4'(w); r.e.kidx = 4'(k); r.e.icol = 4'(i); r.e.odst = 8'(o);
    r.e.shi = 6'(sh); r.e.shw = 6'(sh); r.e.vr = 3'(vr); r.e.vc = 3'(vc);
    return r;
  endfunction

  function automatic exp_t sample();
    return {Busy, Done, Cfg_Err, LOAD, START_CALC, Acc, WROW, KIDX, ICOL, ODST, shI, shW, VROWS, VCOLS};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  task automatic drive(input in_t i);
    RST = i.rst; Start = i.start; M = i.m; N = i.n; T = i.t; Tile_Done = i.td;
  endtask

  int  loads;
  logic done_seen, td_sent, got_done;

  initial begin
    RST = 1'b1; Start = 1'b0; Tile_Done = 1'b0; M = '0; N = '0; T = '0;
`ifdef MAC_TILE_SEQ_ABORT_EN
    Abort = 1'b0;
`endif
    tick();
    tick();

    //         rst st  m  n  t td | B D E L S A  W K I  O sh vr vc
    tbl.push_back(v(1, 0, 0, 0, 0, 0,  0,0,0,0,0,0, 0,0,0, 0, 0, 0,0));
    tbl.push_back(v(0, 0, 0, 0, 0, 1,  0,0,0,0,0,0, 0,0,0, 0, 0, 0,0));
    tbl.push_back(v(1, 1, 4, 4, 4, 0,  0,0,0,0,0,0, 0,0,0, 0, 0, 0,0));
    // Single-tile 4x4x4 job
    tbl.push_back(v(0, 1, 4, 4, 4, 0,  1,0,0,1,0,0, 0,0,0, 0, 0, 4,4));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  1,0,0,0,1,0, 0,0,0, 0, 0, 4,4));
    tbl.push_back(v(0, 0, 0, 0, 0, 1,  1,0,0,0,0,0, 0,0,0, 0, 0, 4,4));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  0,1,0,0,0,0, 0,0,0, 0, 0, 4,4));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  0,0,0,0,0,0, 0,0,0, 0, 0, 4,4));
    // Zero-dimension rejections
    tbl.push_back(v(0, 1, 4, 0, 4, 0,  0,0,1,0,0,0, 0,0,0, 0, 0, 4,4));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  0,0,0,0,0,0, 0,0,0, 0, 0, 4,4));
    tbl.push_back(v(0, 1, 0, 5, 5, 0,  0,0,1,0,0,0, 0,0,0, 0, 0, 4,4));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  0,0,0,0,0,0, 0,0,0, 0, 0, 4,4));
    // 8x8x8 job: eight passes, four loads
    tbl.push_back(v(0, 1, 8, 8, 8, 0,  1,0,0,1,0,0, 0,0,0, 0, 0, 4,4));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  1,0,0,0,1,0, 0,0,0, 0, 0, 4,4));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  1,0,0,0,1,0, 0,0,0, 0, 0, 4,4));
    tbl.push_back(v(0, 0, 0, 0, 0, 1,  1,0,0,0,1,0, 0,0,1, 1, 0, 4,4));
    tbl.push_back(v(0, 0, 0, 0, 0, 1,  1,0,0,1,0,1, 0,1,0, 0, 0, 4,4));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  1,0,0,0,1,1, 0,1,0, 0, 0, 4,4));
    tbl.push_back(v(0, 0, 0, 0, 0, 1,  1,0,0,0,1,1, 0,1,1, 1, 0, 4,4));
    tbl.push_back(v(0, 0, 0, 0, 0, 1,  1,0,0,1,0,0, 1,0,0, 2, 0, 4,4));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  1,0,0,0,1,0, 1,0,0, 2, 0, 4,4));
    tbl.push_back(v(0, 0, 0, 0, 0, 1,  1,0,0,0,1,0, 1,0,1, 3, 0, 4,4));
    tbl.push_back(v(0, 0, 0, 0, 0, 1,  1,0,0,1,0,1, 1,1,0, 2, 0, 4,4));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  1,0,0,0,1,1, 1,1,0, 2, 0, 4,4));
    tbl.push_back(v(0, 1, 4, 4, 4, 1,  1,0,0,0,1,1, 1,1,1, 3, 0, 4,4));
    tbl.push_back(v(0, 0, 0, 0, 0, 1,  1,0,0,0,0,1, 1,1,1, 3, 0, 4,4));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  0,1,0,0,0,1, 1,1,1, 3, 0, 4,4));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  0,0,0,0,0,1, 1,1,1, 3, 0, 4,4));
    // 5x6x3 job: partial rows and partial depth
    tbl.push_back(v(0, 1, 5, 6, 3, 0,  1,0,0,1,0,0, 0,0,0, 0, 0, 4,3));
    tbl.push_back(v(0, 1, 4, 4, 4, 1,  1,0,0,0,1,0, 0,0,0, 0, 0, 4,3));
    tbl.push_back(v(0, 0, 0, 0, 0, 1,  1,0,0,1,0,1, 0,1,0, 0,16, 4,3));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  1,0,0,0,1,1, 0,1,0, 0,16, 4,3));
    tbl.push_back(v(0, 0, 0, 0, 0, 1,  1,0,0,1,0,0, 1,0,0, 1, 0, 1,3));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  1,0,0,0,1,0, 1,0,0, 1, 0, 1,3));
    tbl.push_back(v(0, 0, 0, 0, 0, 1,  1,0,0,1,0,1, 1,1,0, 1,16, 1,3));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  1,0,0,0,1,1, 1,1,0, 1,16, 1,3));
    tbl.push_back(v(0, 0, 0, 0, 0, 1,  1,0,0,0,0,1, 1,1,0, 1,16, 1,3));
    tbl.push_back(v(0, 0, 0, 0, 0, 0,  0,1,0,0,0,1, 1,1,0, 1,16, 1,3));

    foreach (tbl[idx]) begin
      drive(tbl[idx].i);
      tick();
      chk($sformatf("vec%0d", idx), 64'(sample()), 64'(tbl[idx].e));
    end
    RST = 1'b0; Start = 1'b0; Tile_Done = 1'b0; M = '0; N = '0; T = '0;
    tick();

    // Reset during the third pass of an 8x8x8 job
    Start = 1'b1; M = 6'd8; N = 6'd8; T = 6'd8;
    tick();
    Start = 1'b0;
    tick();
    Tile_Done = 1'b1;
    tick();
    tick();
    Tile_Done = 1'b0;
    tick();
    chk("pass3_pos", 64'({START_CALC, KIDX, ICOL}), 64'({1'b1, 4'd1, 4'd0}));
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst_mid_job", 64'(sample()), 64'(0));
    done_seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      Tile_Done = c[0];
      tick();
      done_seen |= Done;
    end
    Tile_Done = 1'b0;
    chk("no_done_after_rst", 64'(done_seen), 64'(0));

    // Restart after reset runs a single-tile job to completion
    Start = 1'b1; M = 6'd4; N = 6'd4; T = 6'd4;
    tick();
    Start = 1'b0;
    loads = int'(LOAD);
    td_sent = 1'b0;
    got_done = 1'b0;
    for (int c = 0; c < 20 && !got_done; c++) begin
      Tile_Done = START_CALC && !td_sent;
      if (Tile_Done) td_sent = 1'b1;
      tick();
      Tile_Done = 1'b0;
      loads += int'(LOAD);
      if (Done) got_done = 1'b1;
    end
    chk("restart_done", 64'(got_done), 64'(1));
    chk("restart_loads", 64'(loads), 64'(1));

`ifdef MAC_TILE_SEQ_ABORT_EN
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    chk("abort_idle_ignored", 64'({Done, Busy}), 64'(0));
    Start = 1'b1; M = 6'd8; N = 6'd8; T = 6'd8;
    tick();
    Start = 1'b0;
    tick();
    Tile_Done = 1'b1;
    tick();
    Abort = 1'b1;
    tick();
    Abort = 1'b0; Tile_Done = 1'b0;
    chk("abort_with_td", 64'({Busy, Done, LOAD, START_CALC, Acc, WROW, KIDX, ICOL}),
        64'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0}));
    tick();
    chk("abort_after", 64'({Busy, Done, LOAD, START_CALC}), 64'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_tile_sequencer.md
MAC_TILE_SEQUENCER -- requirements
Module: mac_tile_sequencer

Interface
REQ-001 Parameter ARR, default 4: systolic array edge (rows = cols = ARR), power of two, 2..16.
REQ-002 Parameter DW, default 6: width of each matrix dimension input.
REQ-003 Parameter TW, default 4: width of tile-index outputs; requires ceil((2^DW-1)/ARR) <= 2^TW.
REQ-004 Parameter SHW, default $clog2(ARR*8)+1: width of shift outputs.
REQ-005 CLK  in  1  single clock; all logic samples on its rising edge.
REQ-006 RST  in  1  synchronous, active-high reset.
REQ-007 Start  in  1  one-cycle job request; M, N and T are sampled with it.
REQ-008 M, N, T  in  DW each  rows of A/C, depth (K), columns of B/C.
REQ-009 Tile_Done  in  1  one-cycle pulse from the output stage: current pass fully written.
REQ-010 Busy  out  1  high from the cycle after an accepted Start until Done.
REQ-011 Done  out  1  one-cycle pulse at job completion.
REQ-012 Cfg_Err  out  1  one-cycle pulse: Start rejected because M, N or T is zero.
REQ-013 LOAD  out  1  one-cycle weight-tile load strobe.
REQ-014 START_CALC  out  1  high throughout each compute pass.
REQ-015 Acc  out  1  pass accumulates into existing output (KIDX != 0).
REQ-016 WROW, KIDX, ICOL  out  TW each  current row-, depth- and column-tile index.
REQ-017 ODST  out  2*TW  output tile address = WROW*total_t + ICOL.
REQ-018 shI, shW  out  SHW each  (ARR - rem_k)*8, where rem_k = min(ARR, N - KIDX*ARR).
REQ-019 VROWS, VCOLS  out  $clog2(ARR)+1 each  valid rows/cols of current tile: min(ARR, M - WROW*ARR), min(ARR, T - ICOL*ARR).

Function
REQ-020 total_x = ceil(x/ARR) for x in {M,N,T}, computed from the values registered at Start.
REQ-021 Loop order: WROW outermost, KIDX middle, ICOL innermost; every (m,k,t) triple visited exactly once.
REQ-022 States: IDLE, LOAD_W, RUN, FIN.
REQ-023 IDLE + Start with all dimensions nonzero: register dimensions, clear indices, LOAD=1 in that cycle, go to LOAD_W.
REQ-024 IDLE + Start with any dimension zero: Cfg_Err=1 in that cycle, stay in IDLE, leave registers unchanged.
REQ-025 LOAD_W lasts exactly one cycle, then RUN.
REQ-026 RUN: START_CALC=1; on Tile_Done, advance indices on the next edge.
REQ-027 On Tile_Done when ICOL wraps to 0 and the job is not finished (weight tile (m,k) changes): LOAD=1 that cycle, go to LOAD_W.
REQ-028 On Tile_Done with ICOL not wrapping: stay in RUN with no LOAD; the weight tile is reused.
REQ-029 On Tile_Done for the last triple: go to FIN; FIN asserts Done for one cycle, then returns to IDLE with Busy low.
REQ-030 Start outside IDLE is ignored; Tile_Done outside RUN is ignored.
REQ-031 Index outputs, shifts, VROWS/VCOLS and Acc are registered and stable for a whole pass.
REQ-032 Indices advance only from Tile_Done; all arithmetic is unsigned, with no overflow for legal parameters.

Reset
REQ-033 When RST=1 at an edge: state=IDLE; all indices, dimension registers and ODST = 0.
REQ-034 Under reset: Busy, Done, Cfg_Err, LOAD, START_CALC and Acc = 0; shI=shW=0; VROWS=VCOLS=0.
REQ-035 Reset mid-job aborts immediately; no Done is issued.
REQ-036 RST has priority over Start and Tile_Done in the same cycle.

Configuration
REQ-037 Macro MAC_TILE_SEQ_ABORT_EN, when defined, adds input port Abort (1 bit).
REQ-038 With the macro defined, Abort=1 in any non-IDLE state returns the block to IDLE next cycle, clears the indices and pulses Done with Cfg_Err=0.
REQ-039 With the macro defined, Abort in IDLE is ignored, and Abort has priority over a same-cycle Tile_Done.
REQ-040 Without the macro, the Abort port does not exist and behaviour is REQ-001..036 only.

Verification
REQ-041 ARR=4, M=N=T=4, Start -> one LOAD; one RUN pass; after Tile_Done, Done pulses 2 cycles later; shI=0.
REQ-042 ARR=4, M=8, N=8, T=8 -> 8 passes in (m,k,t) order; exactly 4 LOADs; Acc=1 on the 4 passes with KIDX=1; ODST sequence 0,1,0,1,2,3,2,3.
REQ-043 ARR=4, M=5, N=6, T=3 -> VROWS 4 then 1; shI 0 on KIDX=0 and 16 on KIDX=1; VCOLS=3 throughout.
REQ-044 Start with N=0 -> Cfg_Err pulses one cycle, Busy stays 0, no LOAD.
REQ-045 RST asserted during the 3rd pass of the REQ-042 job -> all outputs 0 next cycle, no Done; a new Start then runs normally.
REQ-046 With MAC_TILE_SEQ_ABORT_EN: Abort coinciding with Tile_Done in RUN -> IDLE next cycle, Done=1, no LOAD after Abort.
